// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the pushbutton interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_ctrl_pkg;

    // Register index, decoded from bus_addr[3:2]
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MASK    = 2'd2;
    localparam logic [1:0] REG_EDGECFG = 2'd3;

    // 10 ms of stable level at 25 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_CNT_W           = 18;

endpackage

// File: rtl/irq_debounce.sv
// Single-bit 2-FF synchroniser followed by a counter debouncer.
// Latency: 2 + DEBOUNCE_CYCLES clk cycles from src change to stable change.
// Backpressure: none; free-running per clock.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   src     raw asynchronous input level
//   stable  debounced, synchronised level
module irq_debounce #(
    parameter int DEBOUNCE_CYCLES = irq_ctrl_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = irq_ctrl_pkg::DEF_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic src,
    output logic stable
);

    // Terminal count: the level must differ on DEBOUNCE_CYCLES consecutive
    // samples, counted 0 .. DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= src;
            sync_q2 <= sync_q1;
            if (sync_q2 == stable) begin
                // Any return to the accepted level restarts the count,
                // so short glitches never reach the output.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Pushbutton interrupt controller: debounce, edge detect, sticky pending with mask, bus slave.
// Latency: src_in to irq = 3 + DEBOUNCE_CYCLES cycles; bus access completes 1 cycle after bus_sel.
// Backpressure: bus_ready pulses once per access; bus_sel held high re-arms every other cycle.
//
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   src_in[N_SRC]          raw button levels, active high
//   eoi[N_SRC]             one-cycle end-of-interrupt pulses from the CPU
//   irq[N_SRC]             registered level interrupts (pending & mask)
//   bus_sel/we/addr/wdata  peripheral bus request; addr[3:2] selects the register
//   bus_rdata/bus_ready    registered read data and one-cycle completion pulse
module irq_ctrl #(
    parameter int N_SRC           = 3,
    parameter int DEBOUNCE_CYCLES = irq_ctrl_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = irq_ctrl_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] eoi,
    output logic [N_SRC-1:0] irq,
    input  logic             bus_sel,
    input  logic             bus_we,
    input  logic [3:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ready
);

    import irq_ctrl_pkg::*;

    logic [N_SRC-1:0] stable;
    logic [N_SRC-1:0] stable_d;
    logic [N_SRC-1:0] edge_cfg;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;

    // ------------------------------------------------------------------
    // Per-source synchroniser and debouncer
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .resetn (resetn),
            .src    (src_in[i]),
            .stable (stable[i])
        );
    end

    // ------------------------------------------------------------------
    // Edge detection. Events come only from a change of stable, so
    // reprogramming edge_cfg on a steady input never fires.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] fall;
    logic [N_SRC-1:0] evt;

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign evt  = (rise & ~edge_cfg) | (fall & edge_cfg);

    // ------------------------------------------------------------------
    // Bus decode. An access happens on the edge that raises bus_ready;
    // the cycle with bus_ready high never starts another one.
    // ------------------------------------------------------------------
    logic             access;
    logic [1:0]       reg_idx;
    logic             wr_pending;
    logic             wr_mask;
    logic             wr_edgecfg;
    logic [N_SRC-1:0] wdata_src;

    assign access    = bus_sel & ~bus_ready;
    assign reg_idx   = bus_addr[3:2];
    assign wdata_src = bus_wdata[N_SRC-1:0];

    always_comb begin
        wr_pending = 1'b0;
        wr_mask    = 1'b0;
        wr_edgecfg = 1'b0;
        if (access && bus_we) begin
            case (reg_idx)
                REG_PENDING: wr_pending = 1'b1;
                REG_MASK:    wr_mask    = 1'b1;
                REG_EDGECFG: wr_edgecfg = 1'b1;
                default:     ; // STATUS is read-only
            endcase
        end
    end

    // Read data is taken from the pre-access register values, so a
    // PENDING access returns what was pending before any W1C lands.
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_STATUS:  rd_val[N_SRC-1:0] = stable;
            REG_PENDING: rd_val[N_SRC-1:0] = pending;
            REG_MASK:    rd_val[N_SRC-1:0] = mask;
            REG_EDGECFG: rd_val[N_SRC-1:0] = edge_cfg;
            default:     rd_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending and mask next-state. A new event wins over a clear landing
    // in the same cycle so an edge is never lost.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] mask_next;

    assign clr          = eoi | (wr_pending ? wdata_src : '0);
    assign pending_next = (pending & ~clr) | evt;
    assign mask_next    = wr_mask ? wdata_src : mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_d  <= '0;
            pending   <= '0;
            mask      <= '0;
            edge_cfg  <= '0;
            irq       <= '0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            stable_d <= stable;
            pending  <= pending_next;
            mask     <= mask_next;
            if (wr_edgecfg) begin
                edge_cfg <= wdata_src;
            end
            // Using the next-state values gives event-to-irq of one cycle
            // and lets an unmask show up together with bus_ready.
            irq       <= pending_next & mask_next;
            bus_ready <= access;
            bus_rdata <= access ? rd_val : '0;
        end
    end

    // Address byte-lane bits and write data above N_SRC carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_addr[1:0], bus_wdata};

endmodule
